fetch_stage: RTL and testbench

//  - Instruction-fetch stage with IF/ID pipeline register; sits directly upstream of the control unit.
//  - Holds the PC and fetches over a one-outstanding req/ready/rvalid instruction-memory port.
//  - Registers instruction and PC into IF/ID; InstrD[6:0]/[14:12]/[31:25] drive the control unit's Op/funct3/funct7.
//  - Handles stall, flush and branch redirect (PCSrcE/PCTargetE from execute).

---
 rtl/fetch_stage_if.sv | 25 ++
 rtl/fetch_stage.sv | 171 +++++++++++++++++
 tb/tb_fetch_stage.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response port for fetch_stage: one-outstanding
// req/ready handshake for the address, rvalid-qualified data return.
interface fetch_stage_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ready,
      input  imem_rvalid,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ready,
      output imem_rvalid,
      output imem_rdata
   );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID register, skid buffer and redirect handling.
// Optional macro FETCH_MISALIGN_CHK_EN adds the MisalignD flag for unaligned redirect targets.
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               PCSrcE,
   input  logic [31:0]        PCTargetE,
   input  logic               StallD,
   input  logic               FlushD,
   fetch_stage_if.master      imem,
   output logic [31:0]        InstrD,
   output logic [31:0]        PCD,
   output logic [31:0]        PCPlus4D,
   output logic               ValidD
`ifdef FETCH_MISALIGN_CHK_EN
   ,
   output logic               MisalignD
`endif
);

   typedef enum logic [2:0] {IDLE, REQ, WAIT, DROP, SKID} state_t;

   state_t      state_q;
   logic        req_q;
   logic [31:0] pc_q;
   logic [31:0] skid_q;
   logic [31:0] instr_q;
   logic [31:0] pcd_q;
   logic [31:0] pcp4_q;
   logic        valid_q;

   logic [31:0] tgt_d;
   logic [31:0] pc_plus4_d;
   logic        load_wait_d;
   logic        load_skid_d;
   logic        load_d;
   logic [31:0] load_instr_d;

   assign tgt_d        = PCTargetE & ~32'h0000_0003;
   assign pc_plus4_d   = pc_q + 32'd4;
   assign load_wait_d  = (state_q == WAIT) && imem.imem_rvalid && !PCSrcE && !StallD;
   assign load_skid_d  = (state_q == SKID) && !PCSrcE && !StallD;
   assign load_d       = load_wait_d || load_skid_d;
   assign load_instr_d = load_skid_d ? skid_q : imem.imem_rdata;

   assign imem.imem_req  = req_q;
   assign imem.imem_addr = pc_q;
   assign InstrD         = instr_q;
   assign PCD            = pcd_q;
   assign PCPlus4D       = pcp4_q;
   assign ValidD         = valid_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         req_q   <= 1'b0;
         pc_q    <= RESET_PC;
         skid_q  <= '0;
         instr_q <= NOP_INSTR;
         pcd_q   <= '0;
         pcp4_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               state_q <= REQ;
               req_q   <= 1'b1;
            end
            REQ: begin
               if (PCSrcE) begin
                  pc_q <= tgt_d;
                  if (imem.imem_ready) begin
                     state_q <= DROP;
                     req_q   <= 1'b0;
                  end
               end else if (imem.imem_ready) begin
                  state_q <= WAIT;
                  req_q   <= 1'b0;
               end
            end
            WAIT: begin
               if (PCSrcE) begin
                  pc_q <= tgt_d;
                  if (imem.imem_rvalid) begin
                     state_q <= REQ;
                     req_q   <= 1'b1;
                  end else begin
                     state_q <= DROP;
                  end
               end else if (imem.imem_rvalid) begin
                  if (StallD) begin
                     skid_q  <= imem.imem_rdata;
                     state_q <= SKID;
                  end else begin
                     pc_q    <= pc_plus4_d;
                     state_q <= REQ;
                     req_q   <= 1'b1;
                  end
               end
            end
            // PC still addresses the buffered word while parked here.
            SKID: begin
               if (PCSrcE) begin
                  pc_q    <= tgt_d;
                  skid_q  <= '0;
                  state_q <= REQ;
                  req_q   <= 1'b1;
               end else if (!StallD) begin
                  pc_q    <= pc_plus4_d;
                  state_q <= REQ;
                  req_q   <= 1'b1;
               end
            end
            DROP: begin
               if (PCSrcE) begin
                  pc_q <= tgt_d;
               end
               if (imem.imem_rvalid) begin
                  state_q <= REQ;
                  req_q   <= 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               req_q   <= 1'b0;
            end
         endcase

         // A fresh load beats a flush: flush only clears a slot not being refilled.
         if (load_d) begin
            instr_q <= load_instr_d;
            pcd_q   <= pc_q;
            pcp4_q  <= pc_plus4_d;
            valid_q <= 1'b1;
         end else if (FlushD) begin
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
         end
      end
   end

`ifdef FETCH_MISALIGN_CHK_EN
   logic misal_pend_q;
   logic misal_q;

   assign MisalignD = misal_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         misal_pend_q <= 1'b0;
         misal_q      <= 1'b0;
      end else begin
         if (PCSrcE && (state_q != IDLE)) begin
            misal_pend_q <= |PCTargetE[1:0];
         end else if (load_d) begin
            misal_pend_q <= 1'b0;
         end

         if (load_d) begin
            misal_q <= misal_pend_q;
         end else if (FlushD) begin
            misal_q <= 1'b0;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus queues expected fetch addresses
// and IF/ID contents; a negedge monitor compares on each accept / IF/ID change.
module tb_fetch_stage;

   typedef struct packed {
      logic        v;
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pc4;
   } ifid_t;

   logic        clk;
   logic        rst;
   logic        PCSrcE;
   logic [31:0] PCTargetE;
   logic        StallD;
   logic        FlushD;
   logic [31:0] InstrD;
   logic [31:0] PCD;
   logic [31:0] PCPlus4D;
   logic        ValidD;
`ifdef FETCH_MISALIGN_CHK_EN
   logic        MisalignD;
`endif

   fetch_stage_if imem_if();

   fetch_stage #(
      .RESET_PC  (32'h0000_0000),
      .NOP_INSTR (32'h0000_0013)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .PCSrcE    (PCSrcE),
      .PCTargetE (PCTargetE),
      .StallD    (StallD),
      .FlushD    (FlushD),
      .imem      (imem_if),
      .InstrD    (InstrD),
      .PCD       (PCD),
      .PCPlus4D  (PCPlus4D),
      .ValidD    (ValidD)
`ifdef FETCH_MISALIGN_CHK_EN
      ,
      .MisalignD (MisalignD)
`endif
   );

   int unsigned pass_cnt  = 0;
   int unsigned total_cnt = 0;

   ifid_t       exp_ifid[$];
   logic [31:0] exp_addr[$];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   // Monitor: compares whenever the DUT accepts a request or changes IF/ID.
   ifid_t       prev_s;
   ifid_t       cur_s;
   ifid_t       e_s;
   logic [31:0] e_addr;

   initial prev_s = {1'b0, 32'h0000_0013, 32'h0, 32'h0};

   always @(negedge clk) begin
      cur_s = {ValidD, InstrD, PCD, PCPlus4D};
      if (cur_s !== prev_s) begin
         if (exp_ifid.size() == 0) begin
            total_cnt++;
            $display("FAIL ifid_unexpected: got v=%b instr=%h pc=%h, expected no update",
                     cur_s.v, cur_s.instr, cur_s.pc);
         end else begin
            e_s = exp_ifid.pop_front();
            chk("ifid_valid", {31'b0, cur_s.v}, {31'b0, e_s.v});
            chk("ifid_instr", cur_s.instr, e_s.instr);
            chk("ifid_pc",    cur_s.pc,    e_s.pc);
            chk("ifid_pc4",   cur_s.pc4,   e_s.pc4);
         end
         prev_s = cur_s;
      end
      if (imem_if.imem_req && imem_if.imem_ready && !rst) begin
         if (exp_addr.size() == 0) begin
            total_cnt++;
            $display("FAIL accept_unexpected: got addr %h, expected no accept", imem_if.imem_addr);
         end else begin
            e_addr = exp_addr.pop_front();
            chk("imem_addr", imem_if.imem_addr, e_addr);
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_req;
      int n = 0;
      while (!imem_if.imem_req && n < 20) begin
         tick();
         n++;
      end
      if (!imem_if.imem_req) begin
         total_cnt++;
         $display("FAIL req_timeout: imem_req=0 after %0d cycles, expected 1", n);
      end
   endtask

   task automatic accept(input logic [31:0] a);
      wait_req();
      exp_addr.push_back(a);
      imem_if.imem_ready = 1'b1;
      tick();
      imem_if.imem_ready = 1'b0;
   endtask

   task automatic respond(input logic [31:0] d);
      imem_if.imem_rvalid = 1'b1;
      imem_if.imem_rdata  = d;
      tick();
      imem_if.imem_rvalid = 1'b0;
   endtask

   task automatic fetch(input logic [31:0] a, input logic [31:0] d, input logic [31:0] a4);
      accept(a);
      exp_ifid.push_back({1'b1, d, a, a4});
      respond(d);
   endtask

   initial begin
      rst = 1'b0;
      PCSrcE = 1'b0; PCTargetE = '0; StallD = 1'b0; FlushD = 1'b0;
      imem_if.imem_ready = 1'b0; imem_if.imem_rvalid = 1'b0; imem_if.imem_rdata = '0;
      #1 rst = 1'b1;
      tick(); tick();
      chk("rst_req",    {31'b0, imem_if.imem_req}, 32'h0);
      chk("rst_valid",  {31'b0, ValidD}, 32'h0);
      chk("rst_instr",  InstrD, 32'h0000_0013);
      chk("rst_pcd",    PCD, 32'h0);
      chk("rst_pcp4",   PCPlus4D, 32'h0);
      rst = 1'b0;
      chk("idle_noreq", {31'b0, imem_if.imem_req}, 32'h0);
      tick();
      chk("first_req",  {31'b0, imem_if.imem_req}, 32'h1);
      chk("first_addr", imem_if.imem_addr, 32'h0);

      // Back-to-back stream
      fetch(32'h0, 32'h0050_0093, 32'h4);
      chk("op_addi", {25'b0, InstrD[6:0]}, 32'h13);
      fetch(32'h4, 32'h00a0_0113, 32'h8);
      accept(32'h8);
      tick();
      exp_ifid.push_back({1'b1, 32'h0020_81b3, 32'h8, 32'hC});
      respond(32'h0020_81b3);
      chk("op_add", {25'b0, InstrD[6:0]}, 32'h33);

      // Stall across response: parked in skid, no request
      accept(32'hC);
      StallD = 1'b1;
      respond(32'h0030_8213);
      for (int i = 0; i < 2; i++) begin
         chk("skid_noreq", {31'b0, imem_if.imem_req}, 32'h0);
         chk("stall_hold", InstrD, 32'h0020_81b3);
         tick();
      end
      chk("skid_noreq", {31'b0, imem_if.imem_req}, 32'h0);
      StallD = 1'b0;
      exp_ifid.push_back({1'b1, 32'h0030_8213, 32'hC, 32'h10});
      tick();
      chk("unstall_req",  {31'b0, imem_if.imem_req}, 32'h1);
      chk("unstall_addr", imem_if.imem_addr, 32'h10);

      // Redirect in WAIT with flush: late response discarded
      accept(32'h10);
      PCSrcE = 1'b1; PCTargetE = 32'h100; FlushD = 1'b1;
      exp_ifid.push_back({1'b0, 32'h0000_0013, 32'hC, 32'h10});
      tick();
      PCSrcE = 1'b0; FlushD = 1'b0;
      respond(32'hDEAD_BEEF);
      chk("drop_valid", {31'b0, ValidD}, 32'h0);
      fetch(32'h100, 32'h0010_0293, 32'h104);

      // Flush and stall together: flush wins
      FlushD = 1'b1; StallD = 1'b1;
      exp_ifid.push_back({1'b0, 32'h0000_0013, 32'h100, 32'h104});
      tick();
      FlushD = 1'b0; StallD = 1'b0;
      chk("flushstall_instr", InstrD, 32'h0000_0013);

      // Redirect coincident with rvalid: data dropped
      accept(32'h104);
      PCSrcE = 1'b1; PCTargetE = 32'h200;
      respond(32'hBADC_0DE3);
      PCSrcE = 1'b0;
      chk("coinc_req",  {31'b0, imem_if.imem_req}, 32'h1);
      chk("coinc_addr", imem_if.imem_addr, 32'h200);
      fetch(32'h200, 32'h0020_0313, 32'h204);

      // Unaligned redirect while request pending
      PCSrcE = 1'b1; PCTargetE = 32'h102;
      tick();
      PCSrcE = 1'b0;
      chk("align_addr", imem_if.imem_addr, 32'h100);
      fetch(32'h100, 32'h0030_0393, 32'h104);
`ifdef FETCH_MISALIGN_CHK_EN
      chk("misalign_set", {31'b0, MisalignD}, 32'h1);
`endif

      // Redirect in the same cycle as acceptance -> DROP
      PCSrcE = 1'b1; PCTargetE = 32'h300;
      accept(32'h104);
      PCSrcE = 1'b0;
      respond(32'h1111_1111);
      fetch(32'h300, 32'h0040_0413, 32'h304);
`ifdef FETCH_MISALIGN_CHK_EN
      chk("misalign_clr", {31'b0, MisalignD}, 32'h0);
`endif

      // PC wrap
      PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC;
      tick();
      PCSrcE = 1'b0;
      fetch(32'hFFFF_FFFC, 32'h0050_0493, 32'h0);
      fetch(32'h0, 32'h0060_0513, 32'h4);

      // Async reset mid-WAIT
      accept(32'h4);
      exp_ifid.push_back({1'b0, 32'h0000_0013, 32'h0, 32'h0});
      rst = 1'b1;
      #1;
      chk("midrst_req",   {31'b0, imem_if.imem_req}, 32'h0);
      chk("midrst_valid", {31'b0, ValidD}, 32'h0);
      chk("midrst_instr", InstrD, 32'h0000_0013);
      chk("midrst_pcd",   PCD, 32'h0);
      chk("midrst_pcp4",  PCPlus4D, 32'h0);
      tick(); tick();
      rst = 1'b0;
      chk("rel_noreq", {31'b0, imem_if.imem_req}, 32'h0);
      tick();
      chk("rel_req",  {31'b0, imem_if.imem_req}, 32'h1);
      chk("rel_addr", imem_if.imem_addr, 32'h0);
      fetch(32'h0, 32'h0070_0593, 32'h4);

      tick(); tick();
      chk("ifid_queue_empty", exp_ifid.size(), 32'h0);
      chk("addr_queue_empty", exp_addr.size(), 32'h0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation still running at %0t, expected completion", $time);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $fatal(1, "timeout");
   end

endmodule
